// File: rtl/mips_regfile.sv
// mips_regfile: 2**AW x DW register file with r0 hardwired to zero, two read ports, a debug read port,
// optional same-cycle write bypass and a saturating committed-write counter.
module mips_regfile #(
   parameter int DW = 32,
   parameter int AW = 5,
   parameter bit BYPASS = 1'b1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [AW-1:0] ra1,
   input  logic [AW-1:0] ra2,
   output logic [DW-1:0] rd1,
   output logic [DW-1:0] rd2,
   input  logic          we,
   input  logic [AW-1:0] wa,
   input  logic [DW-1:0] wd,
   input  logic [AW-1:0] dbg_a,
   output logic [DW-1:0] dbg_d,
   output logic [15:0]   wr_cnt
);
   logic [DW-1:0] mem [2**AW];
   logic commit;
   assign commit = we && wa != '0 && !rst;
   // address 0 is masked on every port, so mem[0] is never relied on
   assign rd1   = ra1   == '0 ? '0 : (BYPASS && commit && wa == ra1)   ? wd : mem[ra1];
   assign rd2   = ra2   == '0 ? '0 : (BYPASS && commit && wa == ra2)   ? wd : mem[ra2];
   assign dbg_d = dbg_a == '0 ? '0 : (BYPASS && commit && wa == dbg_a) ? wd : mem[dbg_a];
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 2**AW; i++) mem[i] <= '0;
         wr_cnt <= '0;
      end else if (commit) begin
         mem[wa] <= wd;
         wr_cnt <= wr_cnt + 16'(wr_cnt != 16'hFFFF);
      end
   end
endmodule
